// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Branch target table is a fixed constant; targets are absolute PCs.
package fetch_unit_pkg;

  localparam int unsigned FetchAddrW = 9;
  localparam int unsigned FetchWordW = 9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } fetch_state_e;

  localparam logic [FetchAddrW-1:0] BranchLut [8] = '{
    9'd10, 9'd3, 9'd20, 9'd100, 9'd255, 9'd400, 9'd505, 9'd511
  };

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, decoder handshake and program start/done.
// master = fetch unit side, slave = ROM/decoder/controller side.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned A = FetchAddrW,
  parameter int unsigned W = FetchWordW
);

  logic         start;
  logic         done;
  logic [A-1:0] prog_addr;
  logic [W-1:0] rom_data;
  logic [W-1:0] inst;
  logic         inst_valid;
  logic         stall;
  logic         taken;
  logic [2:0]   target_idx;
  logic         halt;

  modport master (
    input  start, rom_data, stall, taken, target_idx, halt,
    output done, prog_addr, inst, inst_valid
  );

  modport slave (
    output start, rom_data, stall, taken, target_idx, halt,
    input  done, prog_addr, inst, inst_valid
  );

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch target lookup: 3-bit index to absolute A-bit PC.
module fetch_unit_branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned A = FetchAddrW
) (
  input  logic [2:0]   i_target_idx,
  output logic [A-1:0] o_target
);

  assign o_target = A'(BranchLut[i_target_idx]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM and registers the returned word.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating 16-bit RUN-cycle counter output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned  A        = FetchAddrW,
  parameter int unsigned  W        = FetchWordW,
  parameter logic [A-1:0] START_PC = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic [15:0]  o_cycle_count,
`endif
  fetch_unit_if.master io_bus
);

  fetch_state_e r_state, w_state_next;
  logic [A-1:0] r_prog_addr, w_prog_addr_next;
  logic [W-1:0] r_inst, w_inst_next;
  logic         r_inst_valid, w_inst_valid_next;
  logic         r_done, w_done_next;
  logic [A-1:0] w_branch_target;

  fetch_unit_branch_lut #(
    .A (A)
  ) u_branch_lut (
    .i_target_idx (io_bus.target_idx),
    .o_target     (w_branch_target)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_prog_addr  <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prog_addr  <= w_prog_addr_next;
      r_inst       <= w_inst_next;
      r_inst_valid <= w_inst_valid_next;
      r_done       <= w_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_prog_addr_next  = r_prog_addr;
    w_inst_next       = r_inst;
    w_inst_valid_next = r_inst_valid;
    w_done_next       = r_done;
    unique case (r_state)
      StIdle, StHalted: begin
        if (io_bus.start) begin
          w_state_next      = StRun;
          w_prog_addr_next  = START_PC;
          w_inst_valid_next = 1'b0;
          w_done_next       = 1'b0;
        end
      end
      StRun: begin
        // Halt/Taken refer to the registered word, so they only count when it is live.
        if (io_bus.halt && r_inst_valid) begin
          w_state_next      = StHalted;
          w_inst_valid_next = 1'b0;
          w_done_next       = 1'b1;
        end else if (io_bus.taken && r_inst_valid) begin
          w_prog_addr_next  = w_branch_target;
          w_inst_valid_next = 1'b0;
        end else if (!io_bus.stall) begin
          w_inst_next       = io_bus.rom_data;
          w_inst_valid_next = 1'b1;
          w_prog_addr_next  = r_prog_addr + A'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign io_bus.prog_addr  = r_prog_addr;
  assign io_bus.inst       = r_inst;
  assign io_bus.inst_valid = r_inst_valid;
  assign io_bus.done       = r_done;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;
  logic        w_start_accept;

  assign w_start_accept = io_bus.start && (r_state != StRun);

  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_accept) begin
      r_cycle_count <= '0;
    end else if (r_state == StRun && r_cycle_count != 16'hFFFF) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized control against a
// cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned A = 9;
  localparam int unsigned W = 9;
  localparam logic [8:0] StartPc = 9'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.A(A), .W(W)) bus ();

  logic [8:0] rom [512];
  assign bus.rom_data = rom[bus.prog_addr];

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  fetch_unit #(
    .A        (A),
    .W        (W),
    .START_PC (StartPc)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
`ifdef FETCH_CYCLE_COUNT_EN
    .o_cycle_count (cycle_count),
`endif
    .io_bus        (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit         m_running;
  bit         m_halted;
  logic [8:0] m_pc;
  logic [8:0] m_inst;
  bit         m_valid;
  bit         m_done;
  int         m_cnt;

  function automatic logic [8:0] lut_of(input logic [2:0] idx);
    case (idx)
      3'd0: return 9'd10;
      3'd1: return 9'd3;
      3'd2: return 9'd20;
      3'd3: return 9'd100;
      3'd4: return 9'd255;
      3'd5: return 9'd400;
      3'd6: return 9'd505;
      default: return 9'd511;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs as currently driven.
  task automatic model_step();
    if (rst) begin
      m_running = 0; m_halted = 0;
      m_pc = '0; m_inst = '0; m_valid = 0; m_done = 0; m_cnt = 0;
    end else if (m_running) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (bus.halt && m_valid) begin
        m_running = 0; m_halted = 1; m_valid = 0; m_done = 1;
      end else if (bus.taken && m_valid) begin
        m_pc = lut_of(bus.target_idx);
        m_valid = 0;
      end else if (!bus.stall) begin
        m_inst  = rom[m_pc];
        m_valid = 1;
        m_pc    = 9'((int'(m_pc) + 1) % 512);
      end
    end else if (bus.start) begin
      m_running = 1; m_halted = 0;
      m_pc = StartPc; m_valid = 0; m_done = 0; m_cnt = 0;
    end
  endtask

  task automatic check_all();
    check_eq("prog_addr", 32'(bus.prog_addr), 32'(m_pc));
    check_eq("inst", 32'(bus.inst), 32'(m_inst));
    check_eq("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
    check_eq("done", 32'(bus.done), 32'(m_done));
`ifdef FETCH_CYCLE_COUNT_EN
    check_eq("cycle_count", 32'(cycle_count), 32'(m_cnt));
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit start, input bit stall, input bit taken,
                       input logic [2:0] idx, input bit halt);
    bus.start = start; bus.stall = stall; bus.taken = taken;
    bus.target_idx = idx; bus.halt = halt;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 9'($urandom);
    rom[0] = 9'h001; rom[1] = 9'h049; rom[2] = 9'h081; rom[3] = 9'h0C9;
    rom[8] = 9'h1FF;
    drive(0, 0, 0, 3'd0, 0);

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // Start and straight-line fetch
    drive(1, 0, 0, 3'd0, 0); step(); drive(0, 0, 0, 3'd0, 0);
    check_eq("start_pc", 32'(bus.prog_addr), 32'(StartPc));
    step(); check_eq("seq0", 32'(bus.inst), 32'h001);
    step(); check_eq("seq1", 32'(bus.inst), 32'h049);
    step(); check_eq("seq2", 32'(bus.inst), 32'h081);
    step(); check_eq("seq3", 32'(bus.inst), 32'h0C9);
    check_eq("seq_pc", 32'(bus.prog_addr), 32'd4);
    step();

    // Reset mid-RUN at PC 5, then stays idle
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("rst_pc", 32'(bus.prog_addr), 32'd0);
    step(); step();

    // Taken branch via LUT[2] = 20
    drive(1, 0, 0, 3'd0, 0); step(); drive(0, 0, 0, 3'd0, 0);
    step(); step();
    drive(0, 0, 1, 3'd2, 0); step(); drive(0, 0, 0, 3'd0, 0);
    check_eq("br_bubble", 32'(bus.inst_valid), 32'd0);
    step();
    check_eq("br_inst", 32'(bus.inst), 32'(rom[20]));
    check_eq("br_pc", 32'(bus.prog_addr), 32'd21);

    // Stall at PC 7
    rst = 1'b1; step(); rst = 1'b0;
    drive(1, 0, 0, 3'd0, 0); step(); drive(0, 0, 0, 3'd0, 0);
    repeat (7) step();
    drive(0, 1, 0, 3'd0, 0);
    repeat (3) begin
      step();
      check_eq("stall_pc", 32'(bus.prog_addr), 32'd7);
    end
    drive(0, 0, 0, 3'd0, 0); step();
    check_eq("resume_pc", 32'(bus.prog_addr), 32'd8);

    // Stall and Taken together: branch wins, lands on 511 and wraps
    drive(0, 1, 1, 3'd7, 0); step(); drive(0, 0, 0, 3'd0, 0);
    check_eq("stall_taken_pc", 32'(bus.prog_addr), 32'd511);
    step();
    check_eq("wrap_pc", 32'(bus.prog_addr), 32'd0);
    check_eq("wrap_inst", 32'(bus.inst), 32'(rom[511]));

    // Halt, frozen, then restart
    drive(0, 0, 0, 3'd0, 1); step(); drive(0, 0, 0, 3'd0, 0);
    check_eq("halt_done", 32'(bus.done), 32'd1);
    step(); step();
    drive(1, 0, 0, 3'd0, 0); step(); drive(0, 0, 0, 3'd0, 0);
    check_eq("restart_done", 32'(bus.done), 32'd0);
    step();

    // Randomized control
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 12) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
            3'($urandom), ($urandom % 30) == 0);
      rst = ($urandom % 150) == 0;
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, 3'd0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
